// File: rtl/branch_target_buffer_if.sv
// IF/EX-facing signal bundle for the branch target buffer: lookup request,
// training request and the prediction/statistics results.
interface branch_target_buffer_if;
    logic        query;
    logic [31:0] PC_query;
    logic        store;
    logic [31:0] PC_update;
    logic        taken;
    logic [31:0] Next_PC;
    logic        pred_result;
    logic        hit;
    logic [31:0] predict;
    logic [31:0] update_num;
    logic [31:0] miss_num;

    modport master (
        output query, PC_query, store, PC_update, taken, Next_PC, pred_result,
        input  hit, predict, update_num, miss_num
    );

    modport slave (
        input  query, PC_query, store, PC_update, taken, Next_PC, pred_result,
        output hit, predict, update_num, miss_num
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Fully associative BTB with 2-bit saturating direction counters. Lookup is
// combinational; training from EX and the statistics counters update on clk.
module branch_target_buffer #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input logic                   clk,
    input logic                   clear_n,
    branch_target_buffer_if.slave bus
);

    logic [ENTRIES-1:0] valid;
    logic [29:0]        tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];
    logic [1:0]         ctr    [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr;
    logic [31:0]        update_cnt;
    logic [31:0]        miss_cnt;

    logic               q_hit;
    logic [IDX_W-1:0]   q_idx;
    logic               u_hit;
    logic [IDX_W-1:0]   u_idx;
    logic               have_free;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   victim;
    logic               unused_pc_bits;

    // Tags are word addresses, so the byte-offset bits never take part.
    assign unused_pc_bits = ^bus.PC_update[1:0];

    always_comb begin
        q_hit     = 1'b0;
        q_idx     = '0;
        u_hit     = 1'b0;
        u_idx     = '0;
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (bus.query && valid[i] && tag[i] == bus.PC_query[31:2]) begin
                q_hit = 1'b1;
                q_idx = IDX_W'(i);
            end
            if (valid[i] && tag[i] == bus.PC_update[31:2]) begin
                u_hit = 1'b1;
                u_idx = IDX_W'(i);
            end
        end
        // Scan downwards so the lowest-index free slot is the one that sticks.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
        victim = have_free ? free_idx : rr_ptr;
    end

    assign bus.hit        = q_hit;
    assign bus.predict    = (q_hit && ctr[q_idx][1]) ? target[q_idx] : bus.PC_query + 32'd4;
    assign bus.update_num = update_cnt;
    assign bus.miss_num   = miss_cnt;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            valid      <= '0;
            rr_ptr     <= '0;
            update_cnt <= '0;
            miss_cnt   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else if (bus.store) begin
            update_cnt <= update_cnt + 32'd1;
            if (!bus.pred_result) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (u_hit) begin
                if (bus.taken) begin
                    target[u_idx] <= bus.Next_PC;
                    if (ctr[u_idx] != 2'b11) begin
                        ctr[u_idx] <= ctr[u_idx] + 2'b01;
                    end
                end else if (ctr[u_idx] != 2'b00) begin
                    ctr[u_idx] <= ctr[u_idx] - 2'b01;
                end
            end else if (bus.taken) begin
                valid[victim]  <= 1'b1;
                tag[victim]    <= bus.PC_update[31:2];
                target[victim] <= bus.Next_PC;
                ctr[victim]    <= 2'b10;
                // Round-robin only moves when a live entry was displaced.
                if (!have_free) begin
                    rr_ptr <= rr_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: an abstract table model is compared
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_branch_target_buffer;
    localparam int ENTRIES = 8;

    logic clk;
    logic clear_n;
    int   checks;
    int   errors;
    bit   compare_en;

    branch_target_buffer_if bus ();

    branch_target_buffer #(.ENTRIES(ENTRIES), .IDX_W(3)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference table: a list of (valid, word address, target, confidence 0..3).
    bit          m_valid  [ENTRIES];
    logic [29:0] m_word   [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_conf   [ENTRIES];
    int          m_rr;
    logic [31:0] m_upd;
    logic [31:0] m_miss;

    task automatic reset_model();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_conf[i]  = 1;
        end
        m_rr   = 0;
        m_upd  = 0;
        m_miss = 0;
    endtask

    function automatic int model_find(input logic [31:0] pc);
        int found = -1;
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_word[i] == pc[31:2]) found = i;
        return found;
    endfunction

    always @(posedge clk) begin
        int idx;
        int slot;
        if (clear_n && bus.store) begin
            m_upd = m_upd + 1;
            if (!bus.pred_result) m_miss = m_miss + 1;
            idx = model_find(bus.PC_update);
            if (idx >= 0) begin
                if (bus.taken) begin
                    m_conf[idx]   = (m_conf[idx] == 3) ? 3 : m_conf[idx] + 1;
                    m_target[idx] = bus.Next_PC;
                end else begin
                    m_conf[idx] = (m_conf[idx] == 0) ? 0 : m_conf[idx] - 1;
                end
            end else if (bus.taken) begin
                slot = -1;
                for (int i = 0; i < ENTRIES; i++)
                    if (!m_valid[i] && slot < 0) slot = i;
                if (slot < 0) begin
                    slot = m_rr;
                    m_rr = (m_rr + 1) % ENTRIES;
                end
                m_valid[slot]  = 1;
                m_word[slot]   = bus.PC_update[31:2];
                m_target[slot] = bus.Next_PC;
                m_conf[slot]   = 2;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Model-vs-DUT comparison, mid-cycle, every cycle once enabled.
    always @(negedge clk) begin
        int          idx;
        logic        exp_hit;
        logic [31:0] exp_pred;
        if (compare_en) begin
            idx      = bus.query ? model_find(bus.PC_query) : -1;
            exp_hit  = (idx >= 0);
            exp_pred = (idx >= 0 && m_conf[idx] >= 2) ? m_target[idx] : bus.PC_query + 32'd4;
            check_output("model_hit", {31'd0, bus.hit}, {31'd0, exp_hit});
            check_output("model_predict", bus.predict, exp_pred);
            check_output("model_update_num", bus.update_num, m_upd);
            check_output("model_miss_num", bus.miss_num, m_miss);
        end
    end

    // Drive one cycle of inputs shortly after the rising edge, then sample mid-cycle.
    task automatic apply_stimulus(input logic q, input logic [31:0] pcq,
                                  input logic st, input logic [31:0] pcu,
                                  input logic tk, input logic [31:0] npc,
                                  input logic pr);
        @(posedge clk);
        #2;
        bus.query       = q;
        bus.PC_query    = pcq;
        bus.store       = st;
        bus.PC_update   = pcu;
        bus.taken       = tk;
        bus.Next_PC     = npc;
        bus.pred_result = pr;
        @(negedge clk);
        #1;
    endtask

    task automatic do_query(input logic [31:0] pc);
        apply_stimulus(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic do_store(input logic [31:0] pc, input logic tk,
                            input logic [31:0] npc, input logic pr);
        apply_stimulus(1'b0, pc, 1'b1, pc, tk, npc, pr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        clear_n = 1'b0;
        reset_model();
        bus.query = 1'b0;
        bus.store = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        clear_n = 1'b1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        compare_en  = 0;
        clear_n     = 1'b0;
        bus.query       = 1'b0;
        bus.PC_query    = 32'd0;
        bus.store       = 1'b0;
        bus.PC_update   = 32'd0;
        bus.taken       = 1'b0;
        bus.Next_PC     = 32'd0;
        bus.pred_result = 1'b1;
        reset_model();
        do_reset();
        compare_en = 1;

        do_query(32'h40);
        check_output("reset_hit", {31'd0, bus.hit}, 32'd0);
        check_output("reset_predict", bus.predict, 32'h44);
        check_output("reset_update_num", bus.update_num, 32'd0);
        check_output("reset_miss_num", bus.miss_num, 32'd0);

        do_store(32'h40, 1'b1, 32'h100, 1'b0);
        do_query(32'h40);
        check_output("alloc_hit", {31'd0, bus.hit}, 32'd1);
        check_output("alloc_predict", bus.predict, 32'h100);
        check_output("alloc_update_num", bus.update_num, 32'd1);
        check_output("alloc_miss_num", bus.miss_num, 32'd1);

        do_store(32'h40, 1'b0, 32'h0, 1'b1);
        do_query(32'h40);
        check_output("weak_nt_predict", bus.predict, 32'h44);
        repeat (2) do_store(32'h40, 1'b1, 32'h100, 1'b1);
        do_query(32'h40);
        check_output("strong_t_predict", bus.predict, 32'h100);
        repeat (3) do_store(32'h40, 1'b1, 32'h100, 1'b1);
        do_store(32'h40, 1'b0, 32'h0, 1'b0);
        do_query(32'h40);
        check_output("sat_high_predict", bus.predict, 32'h100);
        repeat (3) do_store(32'h40, 1'b0, 32'h0, 1'b0);
        do_query(32'h40);
        check_output("strong_nt_hit", {31'd0, bus.hit}, 32'd1);
        check_output("strong_nt_predict", bus.predict, 32'h44);
        do_store(32'h40, 1'b1, 32'h100, 1'b1);
        do_query(32'h40);
        check_output("sat_low_predict", bus.predict, 32'h44);
        check_output("train_update_num", bus.update_num, 32'd12);
        check_output("train_miss_num", bus.miss_num, 32'd5);
        apply_stimulus(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_output("noquery_hit", {31'd0, bus.hit}, 32'd0);
        check_output("noquery_predict", bus.predict, 32'h44);

        do_reset();
        for (int i = 0; i <= ENTRIES; i++)
            do_store(32'(i * 4), 1'b1, 32'h1000 + 32'(i * 4), 1'b1);
        do_query(32'h0);
        check_output("evict0_hit", {31'd0, bus.hit}, 32'd0);
        check_output("evict0_predict", bus.predict, 32'h4);
        do_query(32'h20);
        check_output("newest_hit", {31'd0, bus.hit}, 32'd1);
        check_output("newest_predict", bus.predict, 32'h1020);

        apply_stimulus(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0);
        check_output("bypass_hit", {31'd0, bus.hit}, 32'd0);
        check_output("bypass_predict", bus.predict, 32'h84);
        do_query(32'h80);
        check_output("after_same_cycle_predict", bus.predict, 32'h200);
        do_query(32'h4);
        check_output("rr_victim1_hit", {31'd0, bus.hit}, 32'd0);
        do_query(32'h8);
        check_output("rr_keep2_predict", bus.predict, 32'h1008);

        do_query(32'h80);
        #1;
        clear_n = 1'b0;
        reset_model();
        #1;
        check_output("async_hit", {31'd0, bus.hit}, 32'd0);
        check_output("async_update_num", bus.update_num, 32'd0);
        check_output("async_miss_num", bus.miss_num, 32'd0);
        bus.PC_query = 32'hFFFF_FFFC;
        #1;
        check_output("wrap_predict", bus.predict, 32'h0000_0000);

        bus.query     = 1'b0;
        bus.store     = 1'b1;
        bus.PC_update = 32'h300;
        bus.taken     = 1'b1;
        bus.Next_PC   = 32'h400;
        bus.pred_result = 1'b1;
        @(posedge clk);
        #2;
        clear_n = 1'b1;
        @(posedge clk);
        #2;
        bus.store = 1'b0;
        do_query(32'h300);
        check_output("held_store_predict", bus.predict, 32'h400);
        check_output("held_store_update_num", bus.update_num, 32'd1);

        repeat (2) @(posedge clk);
        compare_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
